// File: rtl/apb2axi_pkg.sv
// Shared types for the APB-to-AXI completion path: completion payload,
// arbitration source and output-slot state.
package apb2axi_pkg;

    typedef struct packed {
        logic [7:0] tag;
        logic [1:0] resp;
        logic [7:0] num_beats;
        logic       error;
        logic [7:0] err_beat_idx;
    } completion_entry_t;

    typedef enum logic {
        SRC_RD = 1'b0,
        SRC_WR = 1'b1
    } arb_src_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/apb2axi_cpl_arbiter_if.sv
// Valid/ready completion channel; master drives vld/entry, slave drives rdy.
interface apb2axi_cpl_arbiter_if;

    logic                          vld;
    apb2axi_pkg::completion_entry_t entry;
    logic                          rdy;

    modport master (output vld, output entry, input rdy);
    modport slave  (input vld, input entry, output rdy);

endinterface

// File: rtl/apb2axi_arb2_pick.sv
// Two-way grant selection: round-robin, or read priority with a write
// starvation guard. grant[0] = read, grant[1] = write.
module apb2axi_arb2_pick
    import apb2axi_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic       rd_vld,
    input  logic       wr_vld,
    input  logic       mode,
    input  arb_src_e   last_grant,
    input  logic [3:0] starve_cnt,
    output logic [1:0] grant
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    always_comb begin
        grant = 2'b00;
        if (rd_vld && wr_vld) begin
            if (mode) begin
                grant = (starve_cnt == LIMIT) ? 2'b10 : 2'b01;
            end else begin
                grant = (last_grant == SRC_WR) ? 2'b01 : 2'b10;
            end
        end else if (rd_vld) begin
            grant = 2'b01;
        end else if (wr_vld) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/apb2axi_cpl_arbiter.sv
// Merges read and write completion queues into a single registered
// completion slot toward the directory, with per-source accept counters.
module apb2axi_cpl_arbiter
    import apb2axi_pkg::*;
#(
    parameter int unsigned ARB_MODE     = 0,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                         pclk,
    input  logic                         preset,
    apb2axi_cpl_arbiter_if.slave         rd_cpl,
    apb2axi_cpl_arbiter_if.slave         wr_cpl,
    apb2axi_cpl_arbiter_if.master        cq_dir_cpl,
    output logic [CNT_W-1:0]             arb_rd_cnt,
    output logic [CNT_W-1:0]             arb_wr_cnt,
    output logic                         arb_busy
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_e        state;
    arb_src_e          last_grant;
    logic [3:0]        starve_cnt;
    completion_entry_t slot;
    logic [1:0]        grant;
    logic              grant_rd, grant_wr;
    logic              can_load, rd_hs, wr_hs, in_hs, out_hs;

    apb2axi_arb2_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .rd_vld    (rd_cpl.vld),
        .wr_vld    (wr_cpl.vld),
        .mode      (ARB_MODE != 0),
        .last_grant(last_grant),
        .starve_cnt(starve_cnt),
        .grant     (grant)
    );

    assign {grant_wr, grant_rd} = grant;

    assign out_hs   = (state == ST_HOLD) && cq_dir_cpl.rdy;
    assign can_load = (state == ST_IDLE) || out_hs;

    // Ready is held low throughout reset so nothing is accepted then dropped.
    assign rd_cpl.rdy = !preset && can_load && grant_rd;
    assign wr_cpl.rdy = !preset && can_load && grant_wr;

    assign rd_hs = rd_cpl.vld && rd_cpl.rdy;
    assign wr_hs = wr_cpl.vld && wr_cpl.rdy;
    assign in_hs = rd_hs || wr_hs;

    assign cq_dir_cpl.vld   = (state == ST_HOLD);
    assign cq_dir_cpl.entry = slot;
    assign arb_busy         = (state == ST_HOLD);

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state      <= ST_IDLE;
            slot       <= '0;
            last_grant <= SRC_WR;
        end else if (in_hs) begin
            state      <= ST_HOLD;
            slot       <= rd_hs ? rd_cpl.entry : wr_cpl.entry;
            last_grant <= rd_hs ? SRC_RD : SRC_WR;
        end else if (out_hs) begin
            state <= ST_IDLE;
        end
    end

    // Counts reads granted over a waiting write; any write grant or idle write side clears it.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            starve_cnt <= 4'd0;
        end else if (wr_hs || !wr_cpl.vld) begin
            starve_cnt <= 4'd0;
        end else if (rd_hs && (starve_cnt < LIMIT)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            arb_rd_cnt <= '0;
            arb_wr_cnt <= '0;
        end else begin
            if (rd_hs && (arb_rd_cnt != '1)) begin
                arb_rd_cnt <= arb_rd_cnt + 1'b1;
            end
            if (wr_hs && (arb_wr_cnt != '1)) begin
                arb_wr_cnt <= arb_wr_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb2axi_cpl_arbiter.sv
// Directed bench: round-robin instance (CNT_W=4) and read-priority instance
// (STARVE_LIMIT=4) driven with a vector table and hand-written sequences.
module tb_apb2axi_cpl_arbiter;
    import apb2axi_pkg::*;

    logic pclk   = 1'b0;
    logic preset = 1'b1;
    always #5 pclk = ~pclk;

    apb2axi_cpl_arbiter_if rd0 ();
    apb2axi_cpl_arbiter_if wr0 ();
    apb2axi_cpl_arbiter_if dir0 ();
    apb2axi_cpl_arbiter_if rd1 ();
    apb2axi_cpl_arbiter_if wr1 ();
    apb2axi_cpl_arbiter_if dir1 ();

    logic [3:0]  cnt_rd0, cnt_wr0;
    logic        busy0;
    logic [15:0] cnt_rd1, cnt_wr1;
    logic        busy1;

    apb2axi_cpl_arbiter #(
        .ARB_MODE(0), .STARVE_LIMIT(4), .CNT_W(4)
    ) dut0 (
        .pclk(pclk), .preset(preset), .rd_cpl(rd0), .wr_cpl(wr0), .cq_dir_cpl(dir0),
        .arb_rd_cnt(cnt_rd0), .arb_wr_cnt(cnt_wr0), .arb_busy(busy0)
    );

    apb2axi_cpl_arbiter #(
        .ARB_MODE(1), .STARVE_LIMIT(4), .CNT_W(16)
    ) dut1 (
        .pclk(pclk), .preset(preset), .rd_cpl(rd1), .wr_cpl(wr1), .cq_dir_cpl(dir1),
        .arb_rd_cnt(cnt_rd1), .arb_wr_cnt(cnt_wr1), .arb_busy(busy1)
    );

    typedef struct {
        logic       rv;
        logic [7:0] rt;
        logic       wv;
        logic [7:0] wt;
        logic       dr;
        logic       e_rr;
        logic       e_wr;
        logic       e_vld;
        logic [7:0] e_tag;
        logic [3:0] e_rc;
        logic [3:0] e_wc;
    } vec_t;

    vec_t vt [11];
    int   total = 0;
    int   bad   = 0;

    function automatic completion_entry_t mk(input logic [7:0] t);
        completion_entry_t e;
        e.tag          = t;
        e.resp         = t[1:0];
        e.num_beats    = t + 8'd1;
        e.error        = t[0];
        e.err_beat_idx = ~t;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        preset    = 1'b1;
        rd0.vld   = 1'b0; rd0.entry = '0; wr0.vld = 1'b0; wr0.entry = '0; dir0.rdy = 1'b0;
        rd1.vld   = 1'b0; rd1.entry = '0; wr1.vld = 1'b0; wr1.entry = '0; dir1.rdy = 1'b0;
        repeat (2) @(negedge pclk);
        preset = 1'b0;
    endtask

    initial begin
        //       rv    rt     wv    wt     dr    e_rr  e_wr  e_vld e_tag  e_rc  e_wc
        vt[0]  = '{1'b1, 8'h03, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 4'd0};
        vt[1]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 4'd1, 4'd0};
        vt[2]  = '{1'b1, 8'h10, 1'b1, 8'h20, 1'b1, 1'b0, 1'b1, 1'b0, 8'h03, 4'd1, 4'd0};
        vt[3]  = '{1'b1, 8'h11, 1'b1, 8'h21, 1'b1, 1'b1, 1'b0, 1'b1, 8'h20, 4'd1, 4'd1};
        vt[4]  = '{1'b1, 8'h11, 1'b1, 8'h21, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 4'd2, 4'd1};
        vt[5]  = '{1'b1, 8'h11, 1'b1, 8'h21, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 4'd2, 4'd1};
        vt[6]  = '{1'b1, 8'h12, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 4'd2, 4'd1};
        vt[7]  = '{1'b0, 8'h00, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h12, 4'd3, 4'd1};
        vt[8]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 4'd3, 4'd2};
        vt[9]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 4'd3, 4'd2};
        vt[10] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22, 4'd3, 4'd2};

        do_reset();
        #1;
        chk("rst_vld0", 32'(dir0.vld), 32'd0);
        chk("rst_entry0", 32'(dir0.entry), 32'd0);
        chk("rst_busy0", 32'(busy0), 32'd0);
        chk("rst_rdcnt0", 32'(cnt_rd0), 32'd0);
        chk("rst_wrcnt0", 32'(cnt_wr0), 32'd0);
        chk("rst_vld1", 32'(dir1.vld), 32'd0);
        chk("rst_rdcnt1", 32'(cnt_rd1), 32'd0);

        // Table-driven: inputs applied after the falling edge, checked before the rising edge.
        for (int i = 0; i < 11; i++) begin
            @(negedge pclk);
            rd0.vld   = vt[i].rv;
            rd0.entry = mk(vt[i].rt);
            wr0.vld   = vt[i].wv;
            wr0.entry = mk(vt[i].wt);
            dir0.rdy  = vt[i].dr;
            #1;
            chk($sformatf("v%0d_rd_rdy", i), 32'(rd0.rdy), 32'(vt[i].e_rr));
            chk($sformatf("v%0d_wr_rdy", i), 32'(wr0.rdy), 32'(vt[i].e_wr));
            chk($sformatf("v%0d_vld", i), 32'(dir0.vld), 32'(vt[i].e_vld));
            chk($sformatf("v%0d_busy", i), 32'(busy0), 32'(vt[i].e_vld));
            chk($sformatf("v%0d_rd_cnt", i), 32'(cnt_rd0), 32'(vt[i].e_rc));
            chk($sformatf("v%0d_wr_cnt", i), 32'(cnt_wr0), 32'(vt[i].e_wc));
            if (vt[i].e_vld) begin
                chk($sformatf("v%0d_entry", i), 32'(dir0.entry), 32'(mk(vt[i].e_tag)));
            end
        end

        // Round-robin tie from reset: first grant goes to read.
        do_reset();
        rd0.vld = 1'b1; rd0.entry = mk(8'hAA);
        wr0.vld = 1'b1; wr0.entry = mk(8'hBB);
        dir0.rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            #1;
            chk($sformatf("rr%0d_vld", i), 32'(dir0.vld), 32'd1);
            chk($sformatf("rr%0d_entry", i), 32'(dir0.entry),
                32'(mk((i % 2 == 0) ? 8'hAA : 8'hBB)));
        end
        rd0.vld = 1'b0; wr0.vld = 1'b0;

        // Backpressure: slot held for 5 cycles, then released.
        @(negedge pclk);
        rd0.vld = 1'b1; rd0.entry = mk(8'h55); dir0.rdy = 1'b0;
        #1;
        chk("bp_load_rdy", 32'(rd0.rdy), 32'd1);
        @(negedge pclk);
        rd0.entry = mk(8'h66);
        wr0.vld = 1'b1; wr0.entry = mk(8'h77);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("bp%0d_vld", k), 32'(dir0.vld), 32'd1);
            chk($sformatf("bp%0d_entry", k), 32'(dir0.entry), 32'(mk(8'h55)));
            chk($sformatf("bp%0d_rd_rdy", k), 32'(rd0.rdy), 32'd0);
            chk($sformatf("bp%0d_wr_rdy", k), 32'(wr0.rdy), 32'd0);
            @(negedge pclk);
        end
        dir0.rdy = 1'b1;
        #1;
        chk("bp_rel_wr_rdy", 32'(wr0.rdy), 32'd1);
        chk("bp_rel_rd_rdy", 32'(rd0.rdy), 32'd0);
        @(negedge pclk);
        rd0.vld = 1'b0; wr0.vld = 1'b0;
        #1;
        chk("bp_next_vld", 32'(dir0.vld), 32'd1);
        chk("bp_next_entry", 32'(dir0.entry), 32'(mk(8'h77)));

        // Read priority with starvation guard on the second instance.
        @(negedge pclk);
        rd1.vld = 1'b1; rd1.entry = mk(8'hAA);
        wr1.vld = 1'b1; wr1.entry = mk(8'hBB);
        dir1.rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            #1;
            chk($sformatf("st%0d_entry", i), 32'(dir1.entry),
                32'(mk((i % 5 == 4) ? 8'hBB : 8'hAA)));
        end
        rd1.vld = 1'b0; wr1.vld = 1'b0;
        @(negedge pclk);
        #1;
        chk("st_rd_cnt", 32'(cnt_rd1), 32'd8);
        chk("st_wr_cnt", 32'(cnt_wr1), 32'd2);

        // Counter saturation, then reset while the slot is full.
        do_reset();
        rd0.vld = 1'b1; rd0.entry = mk(8'h5A); dir0.rdy = 1'b1;
        repeat (17) @(negedge pclk);
        rd0.vld = 1'b0; dir0.rdy = 1'b0;
        #1;
        chk("sat_rd_cnt", 32'(cnt_rd0), 32'd15);
        chk("sat_wr_cnt", 32'(cnt_wr0), 32'd0);
        chk("sat_vld", 32'(dir0.vld), 32'd1);
        rd0.vld = 1'b1;
        preset  = 1'b1;
        #1;
        chk("mid_rst_vld", 32'(dir0.vld), 32'd0);
        chk("mid_rst_busy", 32'(busy0), 32'd0);
        chk("mid_rst_rd_rdy", 32'(rd0.rdy), 32'd0);
        chk("mid_rst_rd_cnt", 32'(cnt_rd0), 32'd0);
        chk("mid_rst_entry", 32'(dir0.entry), 32'd0);
        @(negedge pclk);
        preset = 1'b0;
        rd0.vld = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
